// File: rtl/hash_mem_responder.sv
// Word RAM that the hash core uses as its memory, plus a host sequencer.
// The sequencer loads the message, starts the core, waits for done, then streams the hashes out.
module hash_mem_responder #(
  parameter int          DEPTH      = 256,
  parameter logic [15:0] MSG_BASE   = 16'h0000,
  parameter logic [15:0] OUT_BASE   = 16'h0040,
  parameter int          LOAD_WORDS = 20,
  parameter int          OUT_WORDS  = 16,
  parameter int          TIMEOUT    = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        core_start,
  input  logic        core_done,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        dump_valid,
  output logic [31:0] dump_data,
  input  logic        dump_ready,
  output logic        busy,
  output logic        oob_err,
  output logic        timeout_err,
  output logic [7:0]  wr_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if ((int'(MSG_BASE) + LOAD_WORDS > DEPTH) || (int'(OUT_BASE) + OUT_WORDS > DEPTH)) begin : g_cfg_err
    $error("hash_mem_responder: message or output window exceeds DEPTH");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_RUN, S_DUMP_RD, S_DUMP_OUT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] tmo_q, tmo_d;
  logic [7:0]  wr_cnt_q, wr_cnt_d;
  logic        oob_q, oob_d;
  logic        tmo_err_q, tmo_err_d;
  logic [31:0] rd_q, dump_q;

  logic [31:0] mem [DEPTH];

  logic          core_in_range;
  logic [AW-1:0] ld_addr, out_addr;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;

  assign core_in_range = ({16'h0000, mem_addr} < 32'(DEPTH));
  assign ld_addr       = AW'(MSG_BASE + idx_q);
  assign out_addr      = AW'(OUT_BASE + idx_q);

  // Host loads and core writes never overlap in time, so they share one write port.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = ld_addr;
    ram_wdata = ld_data;
    if (state_q == S_LOAD && ld_valid) begin
      ram_we = 1'b1;
    end else if (state_q == S_RUN && mem_we && core_in_range) begin
      ram_we    = 1'b1;
      ram_waddr = mem_addr[AW-1:0];
      ram_wdata = mem_write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  // Read registers sample the pre-write contents, giving read-old-data on collisions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q   <= '0;
      dump_q <= '0;
    end else begin
      if (state_q == S_RUN) rd_q <= core_in_range ? mem[mem_addr[AW-1:0]] : '0;
      if (state_q == S_DUMP_RD) dump_q <= mem[out_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      tmo_q     <= '0;
      wr_cnt_q  <= '0;
      oob_q     <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      wr_cnt_q  <= wr_cnt_d;
      oob_q     <= oob_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    wr_cnt_d  = wr_cnt_q;
    oob_d     = oob_q;
    tmo_err_d = tmo_err_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          wr_cnt_d  = '0;
          oob_d     = 1'b0;
          tmo_err_d = 1'b0;
          idx_d     = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          idx_d = idx_q + 16'd1;
          if (idx_q == 16'(LOAD_WORDS - 1)) state_d = S_START;
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        tmo_d = tmo_q + 32'd1;
        if (mem_we && wr_cnt_q != 8'hFF) wr_cnt_d = wr_cnt_q + 8'd1;
        if (!core_in_range) oob_d = 1'b1;
        // A done arriving on the final timeout cycle still wins.
        if (core_done) begin
          idx_d   = '0;
          state_d = S_DUMP_RD;
        end else if (tmo_q == 32'(TIMEOUT - 1)) begin
          tmo_err_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_DUMP_RD: state_d = S_DUMP_OUT;
      S_DUMP_OUT: begin
        if (dump_ready) begin
          idx_d   = idx_q + 16'd1;
          state_d = (idx_q == 16'(OUT_WORDS - 1)) ? S_IDLE : S_DUMP_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ld_ready      = (state_q == S_LOAD);
  assign core_start    = (state_q == S_START);
  assign dump_valid    = (state_q == S_DUMP_OUT);
  assign busy          = (state_q != S_IDLE);
  assign dump_data     = dump_q;
  assign mem_read_data = rd_q;
  assign oob_err       = oob_q;
  assign timeout_err   = tmo_err_q;
  assign wr_count      = wr_cnt_q;
  assign message_addr  = MSG_BASE;
  assign output_addr   = OUT_BASE;

endmodule

// File: tb/tb_hash_mem_responder.sv
// Directed bench for hash_mem_responder: load/start, core port vectors, dump, timeout, reset abort.
module tb_hash_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        go, ld_valid, core_done, mem_we, dump_ready;
  logic [31:0] ld_data, mem_write_data;
  logic [15:0] mem_addr;
  logic        ld_ready, core_start, dump_valid, busy, oob_err, timeout_err;
  logic [15:0] message_addr, output_addr;
  logic [31:0] mem_read_data, dump_data;
  logic [7:0]  wr_count;

  hash_mem_responder #(
    .DEPTH(256), .MSG_BASE(16'h0000), .OUT_BASE(16'h0040),
    .LOAD_WORDS(20), .OUT_WORDS(16), .TIMEOUT(100)
  ) dut (
    .clk(clk), .reset(reset), .go(go),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .core_start(core_start), .core_done(core_done),
    .message_addr(message_addr), .output_addr(output_addr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .dump_valid(dump_valid), .dump_data(dump_data), .dump_ready(dump_ready),
    .busy(busy), .oob_err(oob_err), .timeout_err(timeout_err), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_oob;
  } vec_t;

  vec_t tbl [9];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic watch_dump = 1'b0;
  logic dump_seen  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (watch_dump && dump_valid) dump_seen = 1'b1;
  endtask

  // go, then 20 words 0x1000+i back-to-back; leaves the DUT in the first RUN cycle.
  task automatic run_load();
    go = 1'b1;
    step();
    go = 1'b0;
    check("ld_ready_up", 32'(ld_ready), 32'd1);
    check("wr_count_clr", 32'(wr_count), 32'd0);
    check("oob_clr", 32'(oob_err), 32'd0);
    check("tmo_clr", 32'(timeout_err), 32'd0);
    ld_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ld_data = 32'h1000 + 32'(i);
      step();
    end
    ld_valid = 1'b0;
    check("ld_ready_drop", 32'(ld_ready), 32'd0);
    check("core_start_hi", 32'(core_start), 32'd1);
    cyc = 0;
    step();
    check("core_start_lo", 32'(core_start), 32'd0);
    check("busy_run", 32'(busy), 32'd1);
  endtask

  initial begin
    int waitc;

    tbl[0] = '{1'b0, 16'd5,     32'h0,    32'h0000_1005, 1'b0};
    tbl[1] = '{1'b0, 16'd6,     32'h0,    32'h0000_1006, 1'b0};
    tbl[2] = '{1'b1, 16'd7,     32'hDEAD, 32'h0000_1007, 1'b0};
    tbl[3] = '{1'b0, 16'd7,     32'h0,    32'h0000_DEAD, 1'b0};
    tbl[4] = '{1'b0, 16'd19,    32'h0,    32'h0000_1013, 1'b0};
    tbl[5] = '{1'b1, 16'h0100,  32'hBAD,  32'h0000_0000, 1'b1};
    tbl[6] = '{1'b0, 16'd0,     32'h0,    32'h0000_1000, 1'b1};
    tbl[7] = '{1'b0, 16'hFFFF,  32'h0,    32'h0000_0000, 1'b1};
    tbl[8] = '{1'b0, 16'd7,     32'h0,    32'h0000_DEAD, 1'b1};

    reset = 1'b1; go = 1'b0; ld_valid = 1'b0; ld_data = '0; core_done = 1'b0;
    mem_we = 1'b0; mem_addr = '0; mem_write_data = '0; dump_ready = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_dump_valid", 32'(dump_valid), 32'd0);
    check("rst_oob", 32'(oob_err), 32'd0);
    check("rst_tmo", 32'(timeout_err), 32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    check("rst_rd_data", mem_read_data, 32'd0);
    check("rst_dump_data", dump_data, 32'd0);
    check("message_addr", 32'(message_addr), 32'h0000);
    check("output_addr", 32'(output_addr), 32'h0040);
    step(); step();
    reset = 1'b0;
    step();

    // Job 1: load, core-port vectors, then let it time out.
    run_load();
    for (int i = 0; i < 20; i++) begin
      mem_addr = 16'(i);
      step();
      check("ram_load_rd", mem_read_data, 32'h1000 + 32'(i));
    end
    for (int i = 0; i < 9; i++) begin
      mem_we = tbl[i].we;
      mem_addr = tbl[i].addr;
      mem_write_data = tbl[i].wdata;
      step();
      check($sformatf("vec%0d_rd", i), mem_read_data, tbl[i].exp_rd);
      check($sformatf("vec%0d_oob", i), 32'(oob_err), 32'(tbl[i].exp_oob));
    end
    mem_we = 1'b0;
    mem_addr = '0;
    watch_dump = 1'b1;
    while (cyc < 100) step();
    check("tmo_busy_c100", 32'(busy), 32'd1);
    check("tmo_err_c100", 32'(timeout_err), 32'd0);
    step();
    check("tmo_idle", 32'(busy), 32'd0);
    check("tmo_err", 32'(timeout_err), 32'd1);
    step(); step();
    watch_dump = 1'b0;
    check("tmo_no_dump", 32'(dump_seen), 32'd0);
    check("oob_sticky", 32'(oob_err), 32'd1);

    // Job 2: core writes 16 hashes, done, dump with back-pressure on word 4.
    run_load();
    mem_we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mem_addr = 16'h0040 + 16'(i);
      mem_write_data = 32'hA0 + 32'(i);
      step();
    end
    mem_we = 1'b0;
    check("wr_count_16", 32'(wr_count), 32'd16);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    for (int w = 0; w < 16; w++) begin
      waitc = 0;
      while (!dump_valid && waitc < 10) begin
        step();
        waitc++;
      end
      check("dump_valid", 32'(dump_valid), 32'd1);
      check($sformatf("dump_word%0d", w), dump_data, 32'hA0 + 32'(w));
      if (w == 4) begin
        for (int k = 0; k < 3; k++) begin
          step();
          check("hold_valid", 32'(dump_valid), 32'd1);
          check("hold_data", dump_data, 32'hA4);
        end
      end
      dump_ready = 1'b1;
      step();
      dump_ready = 1'b0;
      check("dump_gap", 32'(dump_valid), 32'd0);
    end
    check("dump_done_idle", 32'(busy), 32'd0);
    check("dump_wr_count", 32'(wr_count), 32'd16);

    // Job 3: asynchronous reset while a dump word is on offer.
    run_load();
    mem_addr = 16'h0040;
    step();
    check("job3_rd_40", mem_read_data, 32'hA0);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    step();
    check("job3_dump_valid", 32'(dump_valid), 32'd1);
    check("job3_dump_data", dump_data, 32'hA0);
    #2 reset = 1'b1;
    #1;
    check("abort_dump_valid", 32'(dump_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rd_data", mem_read_data, 32'd0);
    step();
    reset = 1'b0;
    step();

    // Job 4: RAM survives the reset; go is ignored while busy.
    run_load();
    mem_addr = 16'h0041;
    step();
    check("persist_41", mem_read_data, 32'hA1);
    mem_addr = 16'h0010;
    go = 1'b1;
    step();
    go = 1'b0;
    check("job4_rd_10", mem_read_data, 32'h1010);
    check("go_ignored_busy", 32'(busy), 32'd1);
    check("go_ignored_ld", 32'(ld_ready), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
